// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect/stall controls and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  func;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, op, rt, func, halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, op, rt, func, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, redirect/stall handling and halt detection.
// state     | meaning
// RUN       | normal fetch; redirect beats stall
// HALT_PEND | halt opcode sits in IF/ID; a redirect can still squash it
// HALTED    | fetch permanently stopped until reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_aligned;
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          // The halt instruction itself is delivered, but the PC stops on it.
          if (bus.imem_rdata[31:26] == HALT_OP) state_d = HALT_PEND;
          else                                  pc_d    = pc_plus4;
        end
      end
      HALT_PEND: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_aligned;
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (!bus.stall) begin
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_pc4    = pc4_q;
  assign bus.ifid_valid  = valid_q;
  assign bus.op          = instr_q[31:26];
  assign bus.rt          = instr_q[20:16];
  assign bus.func        = instr_q[5:0];
  assign bus.halted      = (state_q == HALTED);
  assign bus.fetch_count = count_q;

endmodule
